logic_unit_iter: RTL and testbench
==================================

LOGIC_UNIT_ITER -- requirements
Module: logic_unit_iter

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits.
REQ-002 Parameter LANE, default 4: bits processed per cycle; WIDTH SHALL be an integer multiple of LANE, and LANE >= 1.
REQ-003 Derived N = WIDTH/LANE: number of processing cycles per operation; lane counter width = max(1, clog2(N)).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  request presents op, inA and inB.
REQ-007 in_ready  output  1  unit can accept a request this cycle.
REQ-008 op  input  2  operation: 00 XOR, 01 AND, 10 OR, 11 XNOR.
REQ-009 inA  input  WIDTH  operand A.
REQ-010 inB  input  WIDTH  operand B.
REQ-011 out_valid  output  1  Out and zero hold a completed result.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 Out  output  WIDTH  bitwise result.
REQ-014 zero  output  1  result is all zeros.
REQ-015 busy  output  1  unit is in state BUSY.

Function
REQ-016 FSM states: IDLE, BUSY, DONE; encoding is free, but an illegal state SHALL go to IDLE on the next edge.
REQ-017 IDLE: in_ready=1; when in_valid=1, capture op, inA and inB, clear the result register and lane counter, then go to BUSY.
REQ-018 BUSY: each cycle write result[k*LANE +: LANE] = op(A,B) for that slice, where k = lane counter, LSB lane first; increment k.
REQ-019 BUSY to DONE on the edge that writes lane N-1; for N=1, one BUSY cycle only.
REQ-020 DONE: out_valid=1; Out, zero and captured state SHALL hold stable while out_ready=0.
REQ-021 DONE to IDLE on an edge with out_ready=1; out_valid is 0 the following cycle.
REQ-022 in_ready=0 in BUSY and DONE; in_valid and operand changes in those states are ignored and SHALL NOT alter the in-flight result.
REQ-023 Latency: request accepted at edge E0; out_valid SHALL be 1 starting the cycle after edge EN (N cycles after acceptance).
REQ-024 Throughput with out_ready held at 1 and in_valid held at 1: one accepted request every N+2 cycles.
REQ-025 Out = result register when out_valid=1, else all zeros; zero = out_valid AND (result == 0).
REQ-026 busy=1 exactly when the state is BUSY.
REQ-027 Operands are latched at acceptance; later changes on inA, inB or op SHALL NOT affect the result.
REQ-028 No arithmetic and no carries; each result bit depends only on the same bit index of A and B.

Reset
REQ-029 While rst=1 at an edge: state=IDLE, lane counter=0, result register and captured operands = 0.
REQ-030 After reset: in_ready=1, out_valid=0, busy=0, Out=0, zero=0.
REQ-031 rst overrides all other inputs, including a handshake in the same cycle.
REQ-032 rst asserted mid-operation (BUSY or DONE) SHALL abort the operation with no partial result and no out_valid pulse.

Verification (WIDTH=16, LANE=4 unless stated)
REQ-033 XOR: op=00, A=0xF0F0, B=0xFF00 -> out_valid 4 cycles after acceptance; Out=0x0FF0, zero=0.
REQ-034 AND: op=01, A=0x1234, B=0x0000 -> Out=0x0000, zero=1, out_valid=1.
REQ-035 Backpressure: OR with A=0x00FF, B=0x0F00, out_ready=0 for 3 DONE cycles -> Out=0x0FFF stable; in_ready=0; a second in_valid is ignored; release -> IDLE next cycle.
REQ-036 Reset at the 2nd BUSY cycle -> next cycle in_ready=1, out_valid=0, Out=0; a following XOR of 0xAAAA and 0x5555 gives 0xFFFF.
REQ-037 Back-to-back with in_valid=out_ready=1: acceptances exactly 6 cycles apart; results in request order; operand changes during BUSY have no effect.
REQ-038 WIDTH=32, LANE=8, XNOR, A=B=0xDEADBEEF -> Out=0xFFFFFFFF after 4 cycles; WIDTH=16, LANE=16 -> out_valid 1 cycle after acceptance.

Source files
------------

// File: rtl/logic_unit_iter.sv
// Iterative bitwise logic unit: applies XOR/AND/OR/XNOR to latched operands LANE bits per cycle,
// LSB lane first, then holds the result under a valid/ready handshake until it is taken.
module logic_unit_iter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned N  = WIDTH / LANE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LastLane = CW'(N - 1);
  localparam logic [WIDTH-1:0] LaneMask = WIDTH'({LANE{1'b1}});

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e           r_state, w_state_d;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic [WIDTH-1:0] w_res_d, w_full, w_mask;
  logic [CW-1:0]    r_lane, w_lane_d;
  logic             w_capture;

  // Full-width result is cheap; the mask picks out the lane written this cycle.
  always_comb begin
    w_full = '0;
    case (r_op)
      2'b00:   w_full = r_a ^ r_b;
      2'b01:   w_full = r_a & r_b;
      2'b10:   w_full = r_a | r_b;
      default: w_full = ~(r_a ^ r_b);
    endcase
  end

  assign w_mask = LaneMask << (LANE * 32'(r_lane));

  always_comb begin
    w_state_d = r_state;
    w_lane_d  = r_lane;
    w_res_d   = r_res;
    w_capture = 1'b0;
    case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_capture = 1'b1;
          w_res_d   = '0;
          w_lane_d  = '0;
          w_state_d = StBusy;
        end
      end
      StBusy: begin
        w_res_d = (r_res & ~w_mask) | (w_full & w_mask);
        if (r_lane == LastLane) begin
          w_state_d = StDone;
        end else begin
          w_lane_d = r_lane + CW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_lane  <= '0;
      r_res   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_d;
      r_lane  <= w_lane_d;
      r_res   <= w_res_d;
      if (w_capture) begin
        r_op <= op;
        r_a  <= inA;
        r_b  <= inB;
      end
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign busy      = (r_state == StBusy);
  assign out_valid = (r_state == StDone);
  assign Out       = out_valid ? r_res : '0;
  assign zero      = out_valid && (r_res == '0);

endmodule

// File: tb/tb_logic_unit_iter.sv
// Bench for logic_unit_iter: transaction-level model checked every cycle on the 16/4 instance,
// plus directed literal checks on 16/4, 32/8 and 16/16 instances.
module tb_logic_unit_iter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [1:0]  op;
  logic [15:0] inA, inB, Out;
  logic        in_ready, out_valid, zero, busy;

  logic        iv32, ir32, ov32, z32, b32;
  logic [1:0]  op32;
  logic [31:0] a32, bb32, o32;

  logic        iv1, ir1, ov1, z1, b1;
  logic [1:0]  op1;
  logic [15:0] a1, bb1, o1;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic_unit_iter #(.WIDTH(16), .LANE(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .inA(inA),
    .inB(inB), .out_valid(out_valid), .out_ready(out_ready), .Out(Out), .zero(zero), .busy(busy)
  );

  logic_unit_iter #(.WIDTH(32), .LANE(8)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .op(op32), .inA(a32),
    .inB(bb32), .out_valid(ov32), .out_ready(1'b1), .Out(o32), .zero(z32), .busy(b32)
  );

  logic_unit_iter #(.WIDTH(16), .LANE(16)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .op(op1), .inA(a1),
    .inB(bb1), .out_valid(ov1), .out_ready(1'b1), .Out(o1), .zero(z1), .busy(b1)
  );

  function automatic logic [31:0] lop(input logic [1:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
    case (o)
      2'b00:   return a ^ b;
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return ~(a ^ b);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Transaction model: a request is pending from acceptance until taken; result visible
  // once N cycles have elapsed since acceptance.
  logic        m_pend;
  int          m_cnt;
  logic [15:0] m_res;

  always @(posedge clk) begin
    if (rst) begin
      m_pend <= 1'b0;
      m_cnt  <= 0;
      m_res  <= '0;
    end else if (!m_pend) begin
      if (in_valid) begin
        m_pend <= 1'b1;
        m_cnt  <= 0;
        m_res  <= 16'(lop(op, 32'(inA), 32'(inB)));
      end
    end else if (m_cnt >= N) begin
      if (out_ready) m_pend <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  logic        e_ov;
  logic [15:0] e_out;
  always @(negedge clk) begin
    if (chk_en) begin
      e_ov  = m_pend && (m_cnt == N);
      e_out = e_ov ? m_res : 16'h0;
      chk("cycle", 32'({in_ready, out_valid, busy, zero, Out}),
          32'({!m_pend, e_ov, m_pend && (m_cnt < N), e_ov && (m_res == 16'h0), e_out}));
    end
  end

  task automatic run_main(input string nm, input logic [1:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_out, input logic exp_z);
    int n;
    op = o; inA = a; inB = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    chk({nm, " latency"}, 32'(n), 32'd4);
    chk({nm, " Out"}, 32'(Out), 32'(exp_out));
    chk({nm, " zero"}, 32'(zero), 32'(exp_z));
  endtask

  logic [1:0]  q_op [3] = '{2'b00, 2'b01, 2'b11};
  logic [15:0] q_a  [3] = '{16'h1234, 16'hF0F0, 16'h0F0F};
  logic [15:0] q_b  [3] = '{16'hFFFF, 16'h3C3C, 16'h00FF};
  logic [15:0] q_e  [3] = '{16'hEDCB, 16'h3030, 16'hF00F};
  int          t_acc[3];

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; inA = '0; inB = '0;
    iv32 = 1'b0; op32 = '0; a32 = '0; bb32 = '0;
    iv1 = 1'b0; op1 = '0; a1 = '0; bb1 = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset state", 32'({in_ready, out_valid, busy, Out, zero}), 32'({3'b100, 16'h0, 1'b0}));

    run_main("xor", 2'b00, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0);
    tick();
    chk("xor release", 32'({out_valid, in_ready}), 32'b01);

    run_main("and", 2'b01, 16'h1234, 16'h0000, 16'h0000, 1'b1);
    chk("and valid", 32'(out_valid), 32'd1);
    tick();

    // Backpressure with an ignored second request during DONE.
    out_ready = 1'b0;
    run_main("or", 2'b10, 16'h00FF, 16'h0F00, 16'h0FFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; op = 2'b11; inA = 16'($urandom); inB = 16'($urandom);
      tick();
      chk("bp hold Out", 32'(Out), 32'h0FFF);
      chk("bp in_ready", 32'({in_ready, out_valid}), 32'b01);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp release", 32'({out_valid, in_ready}), 32'b01);

    // Reset during the second BUSY cycle.
    op = 2'b00; inA = 16'h1111; inB = 16'h2222; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("abort was busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", 32'({in_ready, out_valid, busy, Out}), 32'({3'b100, 16'h0}));
    run_main("post-abort xor", 2'b00, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0);
    tick();

    // Reset while holding a result, then reset racing a handshake.
    out_ready = 1'b0;
    run_main("done abort", 2'b10, 16'h0001, 16'h0100, 16'h0101, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    chk("abort done", 32'({in_ready, out_valid, Out}), 32'({2'b10, 16'h0}));
    rst = 1'b1; in_valid = 1'b1; op = 2'b10; inA = 16'hFFFF;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst beats handshake", 32'({in_ready, busy}), 32'b10);

    // Back-to-back with in_valid held high; operands scrambled after each acceptance.
    in_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      op = q_op[r]; inA = q_a[r]; inB = q_b[r];
      tick();
      t_acc[r] = cyc;
      op = 2'(r); inA = 16'($urandom); inB = 16'($urandom);
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
      chk("b2b Out", 32'(Out), 32'(q_e[r]));
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin tick(); n++; end
      chk("b2b return idle", 32'(n), 32'd1);
    end
    in_valid = 1'b0;
    chk("b2b spacing 0-1", 32'(t_acc[1] - t_acc[0]), 32'd6);
    chk("b2b spacing 1-2", 32'(t_acc[2] - t_acc[1]), 32'd6);
    tick();

    // 32/8 instance: XNOR of equal operands.
    op32 = 2'b11; a32 = 32'hDEADBEEF; bb32 = 32'hDEADBEEF; iv32 = 1'b1;
    tick();
    iv32 = 1'b0; a32 = 32'h0; op32 = 2'b00;
    n = 0;
    while (ov32 !== 1'b1 && n < 20) begin tick(); n++; end
    chk("w32 latency", 32'(n), 32'd4);
    chk("w32 Out", o32, 32'hFFFFFFFF);
    chk("w32 zero", 32'(z32), 32'd0);
    tick();
    chk("w32 idle", 32'({ir32, ov32}), 32'b10);

    // 16/16 instance: single BUSY cycle.
    op1 = 2'b01; a1 = 16'hF0F0; bb1 = 16'h3C3C; iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    chk("n1 busy", 32'(b1), 32'd1);
    n = 0;
    while (ov1 !== 1'b1 && n < 20) begin tick(); n++; end
    chk("n1 latency", 32'(n), 32'd1);
    chk("n1 Out", 32'(o1), 32'h3030);
    tick();
    op1 = 2'b00; a1 = 16'h5A5A; bb1 = 16'h5A5A; iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    tick();
    chk("n1 zero", 32'({ov1, z1, o1}), 32'({2'b11, 16'h0}));
    tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
